lab2_disp_scheduler: RTL and testbench

//  Time-multiplex controller for the two-digit seven-segment display path.
//  - Drives the mux select (enabler) and a blanking strobe with fixed dwell and dead-time,
//    so digit enables never overlap and segments do not ghost.
//  - Double-buffers both digit nibbles; new values commit only on a frame boundary (no tearing).
//  - Sits between the input/keypad logic and the 2:1 digit mux / segment decoder.

---
 rtl/lab2_disp_scheduler.sv | 98 +++++++++
 tb/tb_lab2_disp_scheduler.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lab2_disp_scheduler.sv
// Two-digit seven-segment display scheduler: show/blank dwell FSM with frame-aligned digit commit.
// Optional brightness PWM on the show states is built when LAB2_DIM_EN is defined.
module lab2_disp_scheduler #(
  parameter int REFRESH_CNT = 24000,
  parameter int BLANK_CNT   = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1_in,
  input  logic [3:0] s2_in,
  input  logic       upd,
`ifdef LAB2_DIM_EN
  input  logic [3:0] duty,
`endif
  output logic [3:0] s1_q,
  output logic [3:0] s2_q,
  output logic       enabler,
  output logic       blank,
  output logic       pending,
  output logic       frame_tick
);
  localparam int MAXC  = (REFRESH_CNT > BLANK_CNT) ? REFRESH_CNT : BLANK_CNT;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_CNT - 1);
  localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'((BLANK_CNT > 0) ? BLANK_CNT - 1 : 0);

  typedef enum logic [1:0] {SHOW1, BLANK1, SHOW2, BLANK2} state_t;

  state_t           state, nstate;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shadow;
  logic             commit, adv, blank_st, show_st;

  always_comb begin
    nstate   = state;
    enabler  = 1'b0;
    blank_st = 1'b0;
    case (state)
      SHOW1: if (cnt == SHOW_LAST) nstate = (BLANK_CNT > 0) ? BLANK1 : SHOW2;
      BLANK1: begin
        blank_st = 1'b1;
        if (cnt == BLK_LAST) nstate = SHOW2;
      end
      SHOW2: begin
        enabler = 1'b1;
        if (cnt == SHOW_LAST) nstate = (BLANK_CNT > 0) ? BLANK2 : SHOW1;
      end
      BLANK2: begin
        enabler  = 1'b1;
        blank_st = 1'b1;
        if (cnt == BLK_LAST) nstate = SHOW1;
      end
      default: nstate = SHOW1;
    endcase
    adv     = (nstate != state);
    commit  = adv && (nstate == SHOW1);
    show_st = ~blank_st;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHOW1;
      cnt        <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= adv ? '0 : cnt + CNT_W'(1);
      frame_tick <= commit;
      if (upd) shadow <= {s1_in, s2_in};
      // An upd landing on the commit edge wins over whatever the shadow held.
      if (commit) begin
        if (upd)          {s1_q, s2_q} <= {s1_in, s2_in};
        else if (pending) {s1_q, s2_q} <= shadow;
        pending <= 1'b0;
      end else if (upd) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef LAB2_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign blank = blank_st | (show_st & (pwm_cnt > duty));
`else
  assign blank = blank_st | (show_st & 1'b0);
`endif

endmodule

// File: tb/tb_lab2_disp_scheduler.sv
// Vector-table bench for lab2_disp_scheduler (REFRESH_CNT=4, BLANK_CNT=2, plus a BLANK_CNT=0 copy).
module tb_lab2_disp_scheduler;
  localparam int NV = 80;

  typedef struct {
    logic       rst, upd;
    logic [3:0] s1, s2;
    logic       en, bl, tk, pd;
    logic [3:0] q1, q2;
    logic       en0, bl0, tk0;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, upd;
  logic [3:0] s1_in, s2_in, duty;
  logic [3:0] s1_q, s2_q, z1_q, z2_q;
  logic       enabler, blank, pending, frame_tick;
  logic       z_en, z_bl, z_pd, z_tk;

  vec_t tbl[NV];
  vec_t sb[$];
  vec_t e;
  int   n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  lab2_disp_scheduler #(.REFRESH_CNT(4), .BLANK_CNT(2)) dut (
    .clk(clk), .reset(reset), .s1_in(s1_in), .s2_in(s2_in), .upd(upd),
`ifdef LAB2_DIM_EN
    .duty(duty),
`endif
    .s1_q(s1_q), .s2_q(s2_q), .enabler(enabler), .blank(blank),
    .pending(pending), .frame_tick(frame_tick));

  lab2_disp_scheduler #(.REFRESH_CNT(4), .BLANK_CNT(0)) dut0 (
    .clk(clk), .reset(reset), .s1_in(s1_in), .s2_in(s2_in), .upd(upd),
`ifdef LAB2_DIM_EN
    .duty(duty),
`endif
    .s1_q(z1_q), .s2_q(z2_q), .enabler(z_en), .blank(z_bl),
    .pending(z_pd), .frame_tick(z_tk));

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic u, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    reset = r; upd = u; s1_in = a; s2_in = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic blank_phase(input int ph);
    return (ph == 4) || (ph == 5) || (ph == 10) || (ph == 11);
  endfunction

  initial begin
    reset = 1'b0; upd = 1'b0; s1_in = '0; s2_in = '0; duty = 4'd15;

    // Stimulus: reset, free run, shadowed updates, last-wins, upd on commit edge, mid-frame reset.
    for (int i = 0; i < NV; i++) begin
      int org, ph, ph8;
      tbl[i] = '{default: '0};
      org = (i >= 67) ? 67 : 0;
      ph  = (i - org) % 12;
      ph8 = (i - org) % 8;
      tbl[i].en  = (ph >= 6);
      tbl[i].bl  = blank_phase(ph);
      tbl[i].tk  = (ph == 0) && (i != org);
      tbl[i].en0 = (ph8 >= 4);
      tbl[i].bl0 = 1'b0;
      tbl[i].tk0 = (ph8 == 0) && (i != org);
      if (i >= 36 && i < 48)      begin tbl[i].q1 = 4'h5; tbl[i].q2 = 4'hA; end
      else if (i >= 48 && i < 60) begin tbl[i].q1 = 4'h7; tbl[i].q2 = 4'h7; end
      else if (i >= 60 && i < 67) begin tbl[i].q1 = 4'h9; tbl[i].q2 = 4'h9; end
      tbl[i].pd = (i >= 27 && i <= 35) || (i >= 38 && i <= 47) ||
                  (i >= 50 && i <= 59) || (i >= 64 && i <= 66);
    end
    tbl[0].rst  = 1'b1;
    tbl[67].rst = 1'b1;
    tbl[27].upd = 1'b1; tbl[27].s1 = 4'h5; tbl[27].s2 = 4'hA;
    tbl[38].upd = 1'b1; tbl[38].s1 = 4'h3; tbl[38].s2 = 4'h3;
    tbl[41].upd = 1'b1; tbl[41].s1 = 4'h7; tbl[41].s2 = 4'h7;
    tbl[50].upd = 1'b1; tbl[50].s1 = 4'h7; tbl[50].s2 = 4'h7;
    tbl[60].upd = 1'b1; tbl[60].s1 = 4'h9; tbl[60].s2 = 4'h9;
    tbl[64].upd = 1'b1; tbl[64].s1 = 4'h6; tbl[64].s2 = 4'h6;

    for (int i = 0; i < NV; i++) begin
      sb.push_back(tbl[i]);
      step(tbl[i].rst, tbl[i].upd, tbl[i].s1, tbl[i].s2);
      e = sb.pop_front();
      chk("enabler", i, enabler, e.en);
      chk("blank", i, blank, e.bl);
      chk("frame_tick", i, frame_tick, e.tk);
      chk("pending", i, pending, e.pd);
      chk("s1_q", i, s1_q, e.q1);
      chk("s2_q", i, s2_q, e.q2);
      chk("nb_enabler", i, z_en, e.en0);
      chk("nb_blank", i, z_bl, e.bl0);
      chk("nb_frame_tick", i, z_tk, e.tk0);
    end

`ifdef LAB2_DIM_EN
    // Dimmed: in show states blank follows pwm_cnt > duty, pwm_cnt = cycles since reset mod 16.
    duty = 4'd3;
    step(1'b1, 1'b0, 4'h0, 4'h0);
    chk("dim_reset_blank", 0, blank, 0);
    for (int k = 1; k < 24; k++) begin
      step(1'b0, 1'b0, 4'h0, 4'h0);
      chk("dim3_blank", k, blank, blank_phase(k % 12) || ((k % 16) > 3));
    end
    duty = 4'd15;
    step(1'b1, 1'b0, 4'h0, 4'h0);
    for (int k = 1; k < 24; k++) begin
      step(1'b0, 1'b0, 4'h0, 4'h0);
      chk("dim15_blank", k, blank, blank_phase(k % 12));
    end
`endif

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
